rgb_to_luma: RTL

Pixel-stream front end that sits directly upstream of the 8-row ping-pong block-reorder buffer. It converts raster-order 24-bit RGB pixels to 8-bit luma (BT.601 full-range, 8-bit fixed-point) through a 3-stage pipeline. It emits an enable-qualified byte stream in the same En/Data form the buffer consumes, plus line-end and frame-end pulses computed from pixel-position counters.

---
 rtl/jpeg_pkg.sv | 45 ++++
 rtl/color_dot3.sv | 62 ++++++
 rtl/rgb_to_luma.sv | 136 +++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG front end: BT.601 full-range colour weights,
// rounding offsets, accumulator width and default image geometry.
package jpeg_pkg;

    // Luma weights (sum to 256)
    localparam int Y_R = 77;
    localparam int Y_G = 150;
    localparam int Y_B = 29;

    // Chroma weights (each row sums to 0)
    localparam int CB_R = -43;
    localparam int CB_G = -85;
    localparam int CB_B = 128;
    localparam int CR_R = 128;
    localparam int CR_G = -107;
    localparam int CR_B = -21;

    // Rounding offset for luma and 128.5 * 256 bias for chroma
    localparam int ROUND      = 128;
    localparam int CHROMA_OFS = 32896;

    // Signed accumulator width; holds every reachable sum including the +256 chroma corner
    localparam int ACC_W = 18;

    // Default image geometry
    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;
    localparam int BLOCK_ROWS = 8;

    // Take bits [ACC_W-1:8] of the accumulator and clamp them to an unsigned byte.
    function automatic logic [7:0] sat_u8(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-9:0] q;
        logic [7:0]              res;
        q = acc[ACC_W-1:8];
        if (q < 0) begin
            res = 8'd0;
        end else if (q > 255) begin
            res = 8'hFF;
        end else begin
            res = q[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/color_dot3.sv
// Three-term signed multiply-accumulate over 8-bit unsigned inputs:
// S1 registers the products, S2 the sum plus offset, S3 the shifted and
// saturated byte. Each stage updates only when its enable is high, so the
// result holds across bubbles.
module color_dot3
    import jpeg_pkg::*;
#(
    parameter int C0  = Y_R,
    parameter int C1  = Y_G,
    parameter int C2  = Y_B,
    parameter int OFS = ROUND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_s1,
    input  logic       en_s2,
    input  logic       en_s3,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] result
);

    logic signed [ACC_W-1:0] p0_q, p1_q, p2_q;
    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic [7:0]              result_q;

    function automatic logic signed [ACC_W-1:0] mul(input int c, input logic [7:0] x);
        return ACC_W'(c * int'(x));
    endfunction

    // Sum of the three products plus rounding/bias offset
    always_comb begin
        sum_d = p0_q + p1_q + p2_q + ACC_W'(OFS);
    end

    // Three data stages, each gated by the valid bit of the stage feeding it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            sum_q    <= '0;
            result_q <= '0;
        end else begin
            if (en_s1) begin
                p0_q <= mul(C0, r);
                p1_q <= mul(C1, g);
                p2_q <= mul(C2, b);
            end
            if (en_s2) begin
                sum_q <= sum_d;
            end
            if (en_s3) begin
                result_q <= sat_u8(sum_q);
            end
        end
    end

    assign result = result_q;

endmodule

// File: rtl/rgb_to_luma.sv
// RGB888 -> 8-bit luma pipeline (3 cycles) with line/frame position pulses.
// Optional build macro CHROMA_OUT_EN adds saturated Cb/Cr outputs aligned
// with Out_Data.
module rgb_to_luma
    import jpeg_pkg::*;
#(
    parameter int unsigned WIDTH    = IMG_WIDTH,
    parameter int unsigned HEIGHT   = IMG_HEIGHT,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        En_In,
    input  logic [23:0] In_Data,
    output logic        En_Out,
    output logic [7:0]  Out_Data,
    output logic        Line_End,
    output logic        Frame_End
`ifdef CHROMA_OUT_EN
    ,
    output logic [7:0]  Out_Cb,
    output logic [7:0]  Out_Cr
`endif
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [PIPE_LAT-1:0] vld_q;
    logic [COL_W-1:0]    col_d, col_q;
    logic [ROW_W-1:0]    row_d, row_q;
    logic                col_last, row_last;
    logic                s3_load;
    logic                line_end_q, frame_end_q;

    // vld_q[i] is the valid bit of stage S(i+1)
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_LAT-2:0], En_In};
        end
    end

    // S3 loads on this edge; the pixel being loaded is the one the counters point at
    assign s3_load  = vld_q[PIPE_LAT-2];
    assign col_last = (col_q == COL_W'(WIDTH - 1));
    assign row_last = (row_q == ROW_W'(HEIGHT - 1));

    // Column/row advance once per emitted pixel, wrapping at line and frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (s3_load) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position counters and end-of-line/frame pulses registered with Out_Data
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            line_end_q  <= s3_load & col_last;
            frame_end_q <= s3_load & col_last & row_last;
        end
    end

    assign En_Out    = vld_q[PIPE_LAT-1];
    assign Line_End  = line_end_q;
    assign Frame_End = frame_end_q;

    color_dot3 #(
        .C0  (Y_R),
        .C1  (Y_G),
        .C2  (Y_B),
        .OFS (ROUND)
    ) u_luma (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .en_s1  (En_In),
        .en_s2  (vld_q[0]),
        .en_s3  (vld_q[1]),
        .r      (In_Data[23:16]),
        .g      (In_Data[15:8]),
        .b      (In_Data[7:0]),
        .result (Out_Data)
    );

`ifdef CHROMA_OUT_EN
    color_dot3 #(
        .C0  (CB_R),
        .C1  (CB_G),
        .C2  (CB_B),
        .OFS (CHROMA_OFS)
    ) u_cb (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .en_s1  (En_In),
        .en_s2  (vld_q[0]),
        .en_s3  (vld_q[1]),
        .r      (In_Data[23:16]),
        .g      (In_Data[15:8]),
        .b      (In_Data[7:0]),
        .result (Out_Cb)
    );

    color_dot3 #(
        .C0  (CR_R),
        .C1  (CR_G),
        .C2  (CR_B),
        .OFS (CHROMA_OFS)
    ) u_cr (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .en_s1  (En_In),
        .en_s2  (vld_q[0]),
        .en_s3  (vld_q[1]),
        .r      (In_Data[23:16]),
        .g      (In_Data[15:8]),
        .b      (In_Data[7:0]),
        .result (Out_Cr)
    );
`endif

endmodule
